// File: rtl/rx_cfg_pkg.sv
// Shared types and AXI response codes for the RX_Block_AP configuration sequencer.
package rx_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    FINISH
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RESP     = 2'd1,
    ERR_MISMATCH = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/rx_block_cfg_sequencer.sv
// AXI4-Lite master that writes a bank of configuration words into RX_Block_AP
// and optionally reads every word back to confirm it stuck.
module rx_block_cfg_sequencer
  import rx_cfg_pkg::*;
#(
  parameter int          NUM_REGS       = 4,
  parameter int          ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter bit          VERIFY         = 1'b1,
  parameter int          TIMEOUT_CYCLES = 256,
  localparam int         IDX_W          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     start,
  input  logic [NUM_REGS*32-1:0]   cfg_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               err_code,
  output logic [IDX_W-1:0]         err_index,
  output logic [ADDR_W-1:0]        M_AXI_AWADDR,
  output logic [2:0]               M_AXI_AWPROT,
  output logic                     M_AXI_AWVALID,
  input  logic                     M_AXI_AWREADY,
  output logic [31:0]              M_AXI_WDATA,
  output logic [3:0]               M_AXI_WSTRB,
  output logic                     M_AXI_WVALID,
  input  logic                     M_AXI_WREADY,
  input  logic [1:0]               M_AXI_BRESP,
  input  logic                     M_AXI_BVALID,
  output logic                     M_AXI_BREADY,
  output logic [ADDR_W-1:0]        M_AXI_ARADDR,
  output logic [2:0]               M_AXI_ARPROT,
  output logic                     M_AXI_ARVALID,
  input  logic                     M_AXI_ARREADY,
  input  logic [31:0]              M_AXI_RDATA,
  input  logic [1:0]               M_AXI_RRESP,
  input  logic                     M_AXI_RVALID,
  output logic                     M_AXI_RREADY
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state;
  logic [NUM_REGS*32-1:0]  cfg_q;
  logic [IDX_W-1:0]        idx;
  logic [WD_W-1:0]         wd_cnt;
  logic                    wr_accepted;
  logic                    last_idx;
  logic                    wd_hit;
  logic                    fail;
  err_code_t               fail_code;

  function automatic logic [31:0] word_of(input logic [NUM_REGS*32-1:0] bank,
                                          input logic [IDX_W-1:0] i);
    return bank[32*i +: 32];
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] i);
    return BASE_ADDR + ADDR_W'({i, 2'b00});
  endfunction

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = 4'hF;

  // A channel counts as accepted once its VALID has already dropped or is being taken now.
  assign wr_accepted = (!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY);
  assign last_idx    = (idx == IDX_W'(NUM_REGS - 1));
  assign wd_hit      = (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    fail      = 1'b0;
    fail_code = ERR_NONE;
    case (state)
      WR_REQ: begin
        if (!wr_accepted && wd_hit) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != AXI_RESP_OKAY) begin
            fail      = 1'b1;
            fail_code = ERR_RESP;
          end
        end else if (wd_hit) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
      RD_REQ: begin
        if (!M_AXI_ARREADY && wd_hit) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
      RD_RESP: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != AXI_RESP_OKAY) begin
            fail      = 1'b1;
            fail_code = ERR_RESP;
          end else if (M_AXI_RDATA != word_of(cfg_q, idx)) begin
            fail      = 1'b1;
            fail_code = ERR_MISMATCH;
          end
        end else if (wd_hit) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      cfg_q         <= '0;
      idx           <= '0;
      wd_cnt        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= ERR_NONE;
      err_index     <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      done   <= 1'b0;
      wd_cnt <= wd_cnt + WD_W'(1);
      if (fail) begin
        // Abort: drop every handshake signal and leave the rest of the bank untouched.
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
        busy          <= 1'b0;
        error         <= 1'b1;
        err_code      <= fail_code;
        err_index     <= idx;
        state         <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              cfg_q         <= cfg_data;
              idx           <= '0;
              error         <= 1'b0;
              err_code      <= ERR_NONE;
              err_index     <= '0;
              busy          <= 1'b1;
              wd_cnt        <= '0;
              M_AXI_AWADDR  <= addr_of('0);
              M_AXI_WDATA   <= cfg_data[31:0];
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= WR_REQ;
            end
          end
          WR_REQ: begin
            if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
            if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
            if (wr_accepted) begin
              M_AXI_BREADY <= 1'b1;
              state        <= WR_RESP;
            end
          end
          WR_RESP: begin
            if (M_AXI_BVALID) begin
              M_AXI_BREADY <= 1'b0;
              if (!last_idx) begin
                idx           <= idx + IDX_W'(1);
                wd_cnt        <= '0;
                M_AXI_AWADDR  <= addr_of(idx + IDX_W'(1));
                M_AXI_WDATA   <= word_of(cfg_q, idx + IDX_W'(1));
                M_AXI_AWVALID <= 1'b1;
                M_AXI_WVALID  <= 1'b1;
                state         <= WR_REQ;
              end else if (VERIFY) begin
                idx           <= '0;
                wd_cnt        <= '0;
                M_AXI_ARADDR  <= addr_of('0);
                M_AXI_ARVALID <= 1'b1;
                state         <= RD_REQ;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FINISH;
              end
            end
          end
          RD_REQ: begin
            if (M_AXI_ARREADY) begin
              M_AXI_ARVALID <= 1'b0;
              M_AXI_RREADY  <= 1'b1;
              state         <= RD_RESP;
            end
          end
          RD_RESP: begin
            if (M_AXI_RVALID) begin
              M_AXI_RREADY <= 1'b0;
              if (!last_idx) begin
                idx           <= idx + IDX_W'(1);
                wd_cnt        <= '0;
                M_AXI_ARADDR  <= addr_of(idx + IDX_W'(1));
                M_AXI_ARVALID <= 1'b1;
                state         <= RD_REQ;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FINISH;
              end
            end
          end
          FINISH: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_block_cfg_sequencer.sv
// Directed bench: a small AXI4-Lite slave with fault knobs drives the sequencer
// through clean runs, error paths, handshake orderings, timeout and reset.
module tb_rx_block_cfg_sequencer;
  import rx_cfg_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] cfg_data;
  logic         busy, done, error;
  logic [1:0]   err_code;
  logic [1:0]   err_index;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic [2:0]   awprot, arprot;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [1:0]   bresp, rresp;

  rx_block_cfg_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK(clk), .ARESETN(rst_n), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave knobs, written only by the stimulus process
  int          aw_dly [4] = '{default: 0};
  int          w_dly  [4] = '{default: 0};
  logic [31:0] or_mask[4] = '{default: 32'h0};
  logic [31:0] err_addr   = 32'hFFFF_FFFF;
  logic        ar_en      = 1'b1;

  // Slave state, written only by the slave process
  logic [31:0] mem    [4] = '{default: 32'h0};
  int          wr_cnt [4] = '{default: 0};
  int          rd_cnt [4] = '{default: 0};
  int          aw_cnt, w_cnt;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_q, w_data_q;
  logic        s_aw_hs, s_w_hs;
  logic [31:0] s_a, s_d;

  assign awready = (aw_cnt >= aw_dly[awaddr[3:2]]);
  assign wready  = (w_cnt  >= w_dly[awaddr[3:2]]);
  assign arready = ar_en;
  assign s_aw_hs = awvalid && awready;
  assign s_w_hs  = wvalid && wready;
  assign s_a     = s_aw_hs ? awaddr : aw_addr_q;
  assign s_d     = s_w_hs  ? wdata  : w_data_q;

  // Slave responds one cycle after both write channels or the read address are accepted
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_addr_q <= '0; w_data_q <= '0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
    end else begin
      aw_cnt <= s_aw_hs ? 0 : (awvalid ? aw_cnt + 1 : aw_cnt);
      w_cnt  <= s_w_hs  ? 0 : (wvalid  ? w_cnt + 1  : w_cnt);
      if (s_aw_hs) aw_addr_q <= awaddr;
      if (s_w_hs)  w_data_q  <= wdata;
      if (bvalid && bready) bvalid <= 1'b0;
      if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
        wr_cnt[s_a[3:2]] <= wr_cnt[s_a[3:2]] + 1;
        if (s_a == err_addr) bresp <= AXI_RESP_SLVERR;
        else begin
          bresp <= AXI_RESP_OKAY;
          mem[s_a[3:2]] <= s_d;
        end
        bvalid <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        aw_got <= aw_got || s_aw_hs;
        w_got  <= w_got || s_w_hs;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rresp  <= AXI_RESP_OKAY;
        rdata  <= mem[araddr[3:2]] | or_mask[araddr[3:2]];
        rd_cnt[araddr[3:2]] <= rd_cnt[araddr[3:2]] + 1;
      end
    end
  end

  // Protocol monitor: VALID must hold until READY and drop right after it
  int   done_cnt = 0, viol_aw = 0, viol_w = 0, viol_ar = 0;
  logic p_aw = 0, p_awr = 0, p_w = 0, p_wr = 0, p_ar = 0, p_arr = 0;
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (rst_n && !error) begin
      if ((p_aw && !p_awr && !awvalid) || (p_aw && p_awr && awvalid)) viol_aw <= viol_aw + 1;
      if ((p_w  && !p_wr  && !wvalid)  || (p_w  && p_wr  && wvalid))  viol_w  <= viol_w + 1;
      if ((p_ar && !p_arr && !arvalid) || (p_ar && p_arr && arvalid)) viol_ar <= viol_ar + 1;
    end
    p_aw <= awvalid; p_awr <= awready;
    p_w  <= wvalid;  p_wr  <= wready;
    p_ar <= arvalid; p_arr <= arready;
  end

  int total = 0;
  int bad   = 0;
  int wr_base[4], rd_base[4];
  int done_base;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mkCfg(input logic [31:0] w3, w2, w1, w0);
    return {w3, w2, w1, w0};
  endfunction

  // Pulses start for one edge; returns at the negedge of cycle 1
  task automatic applyStimulus(input logic [127:0] cfg);
    @(negedge clk);
    cfg_data = cfg;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic waitFinish(output int n, output bit fin);
    n   = 1;
    fin = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done || error) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic snapshot();
    wr_base   = wr_cnt;
    rd_base   = rd_cnt;
    done_base = done_cnt;
  endtask

  int n;
  bit fin;
  bit found;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    cfg_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ctl", {awvalid, wvalid, bready, arvalid, rready, busy, done, error, err_code, err_index}, 12'h0);
    checkOutput("reset_addr", {awaddr, araddr}, 64'h0);
    checkOutput("reset_wdata", wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] clean run");
    snapshot();
    applyStimulus(mkCfg(32'd4, 32'd3, 32'd2, 32'd1));
    checkOutput("t1_busy_c1", busy, 1);
    waitFinish(n, fin);
    checkOutput("t1_finished", fin, 1);
    checkOutput("t1_done_cycle", n, 17);
    checkOutput("t1_error", {error, err_code}, 3'b000);
    @(negedge clk);
    checkOutput("t1_done_pulse", {done, busy}, 2'b00);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t1_mem%0d", i), mem[i], i + 1);
      checkOutput($sformatf("t1_wr%0d", i), wr_cnt[i] - wr_base[i], 1);
      checkOutput($sformatf("t1_rd%0d", i), rd_cnt[i] - rd_base[i], 1);
    end
    checkOutput("t1_prot_strb", {awprot, arprot, wstrb}, 10'h00F);

    $display("[TB] slave error on write of 0x8");
    err_addr = 32'h8;
    snapshot();
    applyStimulus(mkCfg(32'h44, 32'h33, 32'h22, 32'h11));
    waitFinish(n, fin);
    checkOutput("t2_finished", fin, 1);
    checkOutput("t2_err", {error, err_code, err_index}, {1'b1, 2'd1, 2'd2});
    repeat (4) @(negedge clk);
    checkOutput("t2_no_wr3", wr_cnt[3] - wr_base[3], 0);
    checkOutput("t2_wr2", wr_cnt[2] - wr_base[2], 1);
    checkOutput("t2_no_rd", (rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3]) - (rd_base[0] + rd_base[1] + rd_base[2] + rd_base[3]), 0);
    checkOutput("t2_no_done", done_cnt - done_base, 0);
    checkOutput("t2_busy", busy, 0);
    err_addr = 32'hFFFF_FFFF;

    $display("[TB] stuck bit on register 1");
    or_mask[1] = 32'h1;
    snapshot();
    applyStimulus(mkCfg(32'd4, 32'd3, 32'd2, 32'd1));
    waitFinish(n, fin);
    checkOutput("t3_finished", fin, 1);
    checkOutput("t3_err", {error, err_code, err_index}, {1'b1, 2'd2, 2'd1});
    repeat (4) @(negedge clk);
    checkOutput("t3_rd1", rd_cnt[1] - rd_base[1], 1);
    checkOutput("t3_no_rd2", rd_cnt[2] - rd_base[2], 0);
    checkOutput("t3_no_done", done_cnt - done_base, 0);
    or_mask[1] = 32'h0;

    $display("[TB] handshake orderings");
    aw_dly = '{0, 3, 2, 0};
    w_dly  = '{3, 0, 2, 0};
    snapshot();
    applyStimulus(mkCfg(32'h40, 32'h30, 32'h20, 32'h10));
    waitFinish(n, fin);
    checkOutput("t4_finished", fin, 1);
    checkOutput("t4_error", error, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t4_mem%0d", i), mem[i], 32'h10 * (i + 1));
      checkOutput($sformatf("t4_wr%0d", i), wr_cnt[i] - wr_base[i], 1);
    end
    checkOutput("t4_done_cnt", done_cnt - done_base, 1);
    checkOutput("t4_valid_rules", viol_aw + viol_w + viol_ar, 0);
    aw_dly = '{default: 0};
    w_dly  = '{default: 0};

    $display("[TB] read address timeout");
    ar_en = 1'b0;
    snapshot();
    applyStimulus(mkCfg(32'd4, 32'd3, 32'd2, 32'd1));
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (arvalid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("t5_arvalid_seen", found, 1);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (error) break;
    end
    checkOutput("t5_timeout_cycles", n, 16);
    checkOutput("t5_err", {error, err_code, err_index, arvalid}, {1'b1, 2'd3, 2'd0, 1'b0});
    checkOutput("t5_no_done", done_cnt - done_base, 0);
    ar_en = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] reset mid-write, then clean run with ignored start");
    applyStimulus(mkCfg(32'hA4, 32'hA3, 32'hA2, 32'hA1));
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (bready && awaddr == 32'h4) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("t6_wr_resp1_seen", found, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_reset_ctl", {awvalid, wvalid, bready, arvalid, rready, busy, done, error, err_code, err_index}, 12'h0);
    checkOutput("t6_reset_addr", {awaddr, araddr}, 64'h0);
    checkOutput("t6_reset_wdata", wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    snapshot();
    applyStimulus(mkCfg(32'd8, 32'd7, 32'd6, 32'd5));
    repeat (3) @(negedge clk);
    cfg_data = mkCfg(32'hDEAD, 32'hBEEF, 32'hCAFE, 32'hF00D);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    waitFinish(n, fin);
    checkOutput("t6_finished", fin, 1);
    checkOutput("t6_error", error, 0);
    repeat (12) @(negedge clk);
    checkOutput("t6_done_cnt", done_cnt - done_base, 1);
    checkOutput("t6_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t6_mem%0d", i), mem[i], i + 5);
      checkOutput($sformatf("t6_wr%0d", i), wr_cnt[i] - wr_base[i], 1);
    end
    checkOutput("final_valid_rules", viol_aw + viol_w + viol_ar, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
